// File: rtl/pc_seq_pkg.sv
// Shared state type and default constants for the instruction-fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    ERR
  } state_t;

  localparam logic [31:0]  DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0]  DEF_EXC_PC   = 32'h0000_4180;
  localparam int unsigned  DEF_TIMEOUT  = 16;

  // Wide enough to hold 0..timeout inclusive.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/npc.sv
// Combinational next-PC selection: jump, then taken branch, then sequential.
module npc (
  input  logic [31:0] pc,
  input  logic [31:0] b,
  input  logic [25:0] j,
  input  logic        branch,
  input  logic        aluzero,
  input  logic        jump,
  output logic [31:0] nextpc
);

  logic [31:0] pc4;

  assign pc4 = pc + 32'd4;

  always_comb begin
    nextpc = pc4;
    if (jump)
      nextpc = {pc4[31:28], j, 2'b00};
    else if (branch && aluzero)
      nextpc = b;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: PC register, imem handshake, fetch timeout.
// Optional alignment redirect enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        ex_done,
  input  logic        branch,
  input  logic        aluzero,
  input  logic        jump,
  input  logic [31:0] b,
  input  logic [25:0] j,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        err,
  output logic        misalign,
  output logic [31:0] epc
);

  localparam int unsigned    CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   nextpc;
  logic [31:0]   load_pc;
  logic          retire;

  npc u_npc (
    .pc      (pc),
    .b       (b),
    .j       (j),
    .branch  (branch),
    .aluzero (aluzero),
    .jump    (jump),
    .nextpc  (nextpc)
  );

  assign retire    = (state == EXEC) && ex_done;
  assign imem_addr = imem_req ? pc : '0;

  always_comb begin
    state_n     = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE:  if (!halt) state_n = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        // A late ack on the final allowed cycle still completes the fetch.
        if (imem_ack)         state_n = EXEC;
        else if (cnt == LAST) state_n = ERR;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (ex_done) state_n = halt ? IDLE : FETCH;
      end
      ERR:     err = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      instr <= '0;
      pc    <= RESET_PC;
    end else begin
      if (state == FETCH) begin
        if (imem_ack) begin
          instr <= imem_rdata;
          cnt   <= '0;
        end else if (cnt != LAST) begin
          cnt <= cnt + CW'(1);
        end
      end
      if (retire) pc <= load_pc;
    end
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic bad;

  assign bad     = |nextpc[1:0];
  assign load_pc = bad ? EXC_PC : nextpc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
      epc      <= '0;
    end else begin
      misalign <= retire && bad;
      if (retire && bad) epc <= nextpc;
    end
  end
`else
  assign load_pc  = nextpc;
  assign misalign = 1'b0;
  assign epc      = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer with a transaction-level PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC    = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        ex_done;
  logic        branch;
  logic        aluzero;
  logic        jump;
  logic [31:0] b;
  logic [25:0] j;
  logic        halt;
  logic [31:0] pc;
  logic        err;
  logic        misalign;
  logic [31:0] epc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] mpc;

  pc_sequencer #(
    .RESET_PC (RST_PC),
    .EXC_PC   (EXC),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .ex_done     (ex_done),
    .branch      (branch),
    .aluzero     (aluzero),
    .jump        (jump),
    .b           (b),
    .j           (j),
    .halt        (halt),
    .pc          (pc),
    .err         (err),
    .misalign    (misalign),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic br,
                                             input logic az, input logic jp,
                                             input logic [31:0] bt, input logic [25:0] jt);
    logic [31:0] seq;
    seq = p + 32'd4;
    if (jp)       return (seq & 32'hF000_0000) | ({6'd0, jt} * 32'd4);
    if (br && az) return bt;
    return seq;
  endfunction

  task automatic wait_req();
    int unsigned n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", 32'(imem_req), 32'd1);
  endtask

  task automatic fetch(input int unsigned waits, input logic [31:0] data);
    wait_req();
    check("addr", imem_addr, mpc);
    for (int unsigned i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      ex_done    = 1'($urandom % 2);
      jump       = 1'($urandom % 2);
      branch     = 1'b1;
      aluzero    = 1'b1;
      b          = $urandom;
      j          = 26'($urandom);
      @(negedge clk);
      check("req_hold", 32'(imem_req), 32'd1);
      check("pc_stable_fetch", pc, mpc);
    end
    ex_done    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr", instr, data);
    check("req_in_exec", 32'(imem_req), 32'd0);
  endtask

  task automatic execute(input int unsigned delay, input logic br, input logic az,
                         input logic jp, input logic [31:0] bt, input logic [25:0] jt,
                         input logic h, input logic [31:0] data);
    logic [31:0] exp;
    logic        bad;
    for (int unsigned i = 0; i < delay; i++) begin
      ex_done    = 1'b0;
      imem_ack   = 1'($urandom % 2);
      imem_rdata = $urandom;
      @(negedge clk);
      check("instr_hold", instr, data);
      check("pc_stable_exec", pc, mpc);
    end
    imem_ack = 1'b0;
    ex_done  = 1'b1;
    branch   = br;
    aluzero  = az;
    jump     = jp;
    b        = bt;
    j        = jt;
    halt     = h;
    exp      = model_next(mpc, br, az, jp, bt, jt);
    bad      = (exp % 4) != 0;
    @(negedge clk);
    ex_done = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    if (bad) begin
      check("pc_redirect", pc, EXC);
      check("epc", epc, exp);
      check("misalign_pulse", 32'(misalign), 32'd1);
      mpc = EXC;
    end else begin
      check("pc_next", pc, exp);
      check("misalign_quiet", 32'(misalign), 32'd0);
      mpc = exp;
    end
`else
    check("pc_next", pc, exp);
    check("misalign_tied", 32'(misalign), 32'd0);
    check("epc_tied", epc, 32'd0);
    mpc = exp;
`endif
    check("req_after_done", 32'(imem_req), h ? 32'd0 : 32'd1);
    @(negedge clk);
    check("misalign_one_cycle", 32'(misalign), 32'd0);
    if (h) begin
      repeat (3) begin
        @(negedge clk);
        check("halt_no_req", 32'(imem_req), 32'd0);
      end
      halt = 1'b0;
    end
    if (bad) mpc = mpc;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_err", 32'(err), 32'd0);
    check("rst_instr", instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mpc   = RST_PC;
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; ex_done = 1'b0;
    branch = 1'b0; aluzero = 1'b0; jump = 1'b0; b = '0; j = '0; halt = 1'b0;
    mpc = RST_PC;

    repeat (2) @(negedge clk);
    check("reset_pc", pc, RST_PC);
    check("reset_req", 32'(imem_req), 32'd0);
    check("reset_valid", 32'(instr_valid), 32'd0);
    check("reset_instr", instr, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_epc", epc, 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);

    rst_n = 1'b1;
    check("idle_first_cycle", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("req_second_cycle", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0000_3000);
    d = $urandom; fetch(0, d);
    execute(0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, d);
    check("seq_pc", pc, 32'h0000_3004);

    // Async reset while a fetch is outstanding.
    wait_req();
    #2;
    reset_pulse();

    d = $urandom; fetch(0, d);
    execute(1, 1'b1, 1'b1, 1'b1, 32'h0000_3200, 26'h1223200, 1'b0, d);
    check("jump_priority", pc, 32'h0488_C800);

    d = $urandom; fetch(3, d);
    execute(0, 1'b1, 1'b1, 1'b0, 32'h0000_3200, '0, 1'b0, d);
    check("branch_taken", pc, 32'h0000_3200);
    d = $urandom; fetch(1, d);
    execute(2, 1'b1, 1'b0, 1'b0, 32'h0000_5000, '0, 1'b0, d);
    check("branch_not_taken", pc, 32'h0000_3204);

    d = $urandom; fetch(0, d);
    execute(0, 1'b1, 1'b1, 1'b0, 32'h0000_3202, '0, 1'b1, d);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    check("align_redirect", pc, 32'h0000_4180);
    check("align_epc", epc, 32'h0000_3202);
`else
    check("align_verbatim", pc, 32'h0000_3202);
`endif

    // Ack on the last allowed FETCH cycle still wins over the timeout.
    d = $urandom; fetch(15, d);
    check("late_ack_err", 32'(err), 32'd0);
    execute(0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, '0, 1'b0, d);
    d = $urandom; fetch(0, d);
    execute(0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, d);
    check("pc_wrap", pc, 32'h0000_0000);

    for (int unsigned n = 0; n < 40; n++) begin
      logic [31:0] bt;
      bt = $urandom;
      if ($urandom % 4 != 0) bt[1:0] = 2'b00;
      d = $urandom;
      fetch($urandom_range(0, 6), d);
      execute($urandom_range(0, 3), 1'($urandom % 2), 1'($urandom % 2),
              ($urandom % 5) == 0, bt, 26'($urandom), ($urandom % 6) == 0, d);
    end

    // Timeout: start from a clean FETCH entry after a halt.
    d = $urandom; fetch(0, d);
    execute(0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, d);
    wait_req();
    for (int unsigned i = 1; i < 16; i++) begin
      @(negedge clk);
      check("timeout_req", 32'(imem_req), 32'd1);
    end
    @(negedge clk);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_req_off", 32'(imem_req), 32'd0);
    repeat (4) begin
      imem_ack = 1'b1; ex_done = 1'b1;
      @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
      check("err_no_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0; ex_done = 1'b0;
    reset_pulse();
    d = $urandom; fetch(2, d);
    execute(0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, d);
    check("recover_pc", pc, 32'h0000_3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
